// File: rtl/bin2bcd_pkg.sv
// Shared constants and helpers for the 32-bit binary to 10-digit BCD converter.
// Build option: BIN2BCD_PIPE_EN selects the 4-stage pipelined datapath.
package bin2bcd_pkg;

   localparam int BIN_W           = 32;
   localparam int DIGITS          = 10;
   localparam int BCD_W           = 40;
   localparam int STEPS_PER_STAGE = 8;
   localparam int VEC_W           = BCD_W + BIN_W;

`ifdef BIN2BCD_PIPE_EN
   localparam int NUM_STAGES = BIN_W / STEPS_PER_STAGE;
`else
   localparam int NUM_STAGES = 1;
`endif

   // Input register plus one register per extra stage; the output register
   // closes the last stage, so latency equals the stage count.
   localparam int LATENCY = NUM_STAGES;

   typedef logic [3:0] bcd_digit_t;

   // Double-dabble correction applied to each digit before a shift.
   function automatic bcd_digit_t add3(input bcd_digit_t d);
      return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
   endfunction

endpackage

// File: rtl/bin2bcd_step.sv
// One double-dabble step on the combined {bcd, binary} vector:
// correct every BCD digit >= 5 by +3, then shift the whole vector left by one.
// Build option: none (shared by both BIN2BCD_PIPE_EN builds).
module bin2bcd_step
   import bin2bcd_pkg::*;
(
   input  logic [VEC_W-1:0] vec_in,
   output logic [VEC_W-1:0] vec_out
);

   logic [VEC_W-1:0] adj;
   logic             unused_msb;

   // Add-3 correction of each BCD digit, binary part untouched.
   always_comb begin
      adj = vec_in;
      for (int d = 0; d < DIGITS; d++) begin
         adj[BIN_W + 4*d +: 4] = add3(vec_in[BIN_W + 4*d +: 4]);
      end
   end

   // The top bit never carries a one for 32-bit inputs (max MSD is 4).
   assign {unused_msb, vec_out} = {adj, 1'b0};

endmodule

// File: rtl/bin2bcd.sv
// 32-bit unsigned binary to 10-digit packed BCD converter (double dabble).
// Build option: BIN2BCD_PIPE_EN inserts a register every 8 steps (latency 4);
// without it all 32 steps are combinational between input and output
// registers (latency 1). Throughput is one conversion per cycle either way.
module bin2bcd
   import bin2bcd_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [BIN_W-1:0] in,
   output logic             out_valid,
   output logic [BCD_W-1:0] bcd
);

   logic [VEC_W-1:0]      stage_q [NUM_STAGES];
   logic [NUM_STAGES-1:0] stage_vld;
   logic [VEC_W-1:0]      chain_in  [BIN_W];
   logic [VEC_W-1:0]      chain_out [BIN_W];
   logic                  unused_bits;

   // 32 chained steps; a stage register feeds the first step of each stage.
   for (genvar s = 0; s < BIN_W; s++) begin : g_step
      if ((s % STEPS_PER_STAGE) == 0 && (s / STEPS_PER_STAGE) < NUM_STAGES) begin : g_reg_in
         assign chain_in[s] = stage_q[s / STEPS_PER_STAGE];
      end else begin : g_comb_in
         assign chain_in[s] = chain_out[s-1];
      end
      bin2bcd_step u_step (
         .vec_in  (chain_in[s]),
         .vec_out (chain_out[s])
      );
   end

   // Binary half is fully shifted out after the last step.
   assign unused_bits = ^chain_out[BIN_W-1][BIN_W-1:0];

   // Input capture and inter-stage registers, each stage with its own valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_vld <= '0;
         for (int k = 0; k < NUM_STAGES; k++) begin
            stage_q[k] <= '0;
         end
      end else begin
         stage_vld[0] <= in_valid;
         if (in_valid) begin
            stage_q[0] <= {{BCD_W{1'b0}}, in};
         end
         for (int k = 1; k < NUM_STAGES; k++) begin
            stage_vld[k] <= stage_vld[k-1];
            if (stage_vld[k-1]) begin
               stage_q[k] <= chain_out[k*STEPS_PER_STAGE - 1];
            end
         end
      end
   end

   // Output register: loads only on a valid result so bcd holds in between.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         bcd       <= '0;
      end else begin
         out_valid <= stage_vld[NUM_STAGES-1];
         if (stage_vld[NUM_STAGES-1]) begin
            bcd <= chain_out[BIN_W-1][VEC_W-1:BIN_W];
         end
      end
   end

endmodule

// File: tb/tb_bin2bcd.sv
// Self-checking bench for bin2bcd: vector table, hand-written stream/reset
// sequences, and a scoreboard fed at input capture and drained at output.
module tb_bin2bcd;
   import bin2bcd_pkg::*;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic [BIN_W-1:0] in;
   logic             out_valid;
   logic [BCD_W-1:0] bcd;

   bin2bcd dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in        (in),
      .out_valid (out_valid),
      .bcd       (bcd)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [BIN_W-1:0] val;
      logic [BCD_W-1:0] exp;
      int               cyc_in;
   } sb_t;

   typedef struct {
      logic [BCD_W-1:0] bcd;
      int               cyc;
   } log_t;

   typedef struct {
      logic [BIN_W-1:0] val;
      logic [BCD_W-1:0] exp;
   } vec_t;

   sb_t              sb_q[$];
   log_t             out_log[$];
   int               total = 0;
   int               bad   = 0;
   int               cyc   = 0;
   bit               mon_en = 1'b0;
   logic [BCD_W-1:0] last_bcd = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: repeated division by ten, independent of the shift-add-3 path.
   function automatic logic [BCD_W-1:0] to_bcd(input logic [BIN_W-1:0] v);
      longint unsigned  x;
      logic [BCD_W-1:0] r;
      x = longint'(v);
      r = '0;
      for (int k = 0; k < DIGITS; k++) begin
         r[4*k +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic longint unsigned recon(input logic [BCD_W-1:0] b);
      longint unsigned r;
      r = 0;
      for (int k = DIGITS-1; k >= 0; k--) begin
         r = r * 10 + longint'(b[4*k +: 4]);
      end
      return r;
   endfunction

   function automatic bit digits_ok(input logic [BCD_W-1:0] b);
      for (int k = 0; k < DIGITS; k++) begin
         if (b[4*k +: 4] > 4'd9) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Scoreboard push at the capturing edge; reset flushes everything in flight.
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         sb_q.delete();
         last_bcd = '0;
      end else if (in_valid) begin
         sb_q.push_back('{val: in, exp: to_bcd(in), cyc_in: cyc});
      end
   end

   // Output monitor away from the active edge.
   always @(negedge clk) begin
      if (mon_en) begin
         if (out_valid) begin
            out_log.push_back('{bcd: bcd, cyc: cyc});
            if (sb_q.size() == 0) begin
               check("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
               sb_t e;
               e = sb_q.pop_front();
               check("sb_bcd", 64'(bcd), 64'(e.exp));
               check("sb_recon", 64'(recon(bcd)), 64'(e.val));
               check("sb_digits", 64'(digits_ok(bcd)), 64'd1);
               check("sb_latency", 64'(cyc - e.cyc_in), 64'(LATENCY));
            end
            last_bcd = bcd;
         end else begin
            check("bcd_hold", 64'(bcd), 64'(last_bcd));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs[9];
      logic [BCD_W-1:0] stream_exp[4];
      bit   got;
      int   rst_edge;
      int   exp_post;

      vecs[0] = '{val: 32'd0,          exp: 40'h0000000000};
      vecs[1] = '{val: 32'd4294967295, exp: 40'h4294967295};
      vecs[2] = '{val: 32'd1234567890, exp: 40'h1234567890};
      vecs[3] = '{val: 32'd9,          exp: 40'h0000000009};
      vecs[4] = '{val: 32'd10,         exp: 40'h0000000010};
      vecs[5] = '{val: 32'd99,         exp: 40'h0000000099};
      vecs[6] = '{val: 32'd100,        exp: 40'h0000000100};
      vecs[7] = '{val: 32'd5,          exp: 40'h0000000005};
      vecs[8] = '{val: 32'd1000000000, exp: 40'h1000000000};
      stream_exp[0] = 40'h09;
      stream_exp[1] = 40'h10;
      stream_exp[2] = 40'h99;
      stream_exp[3] = 40'h100;

      rst = 1'b1; in_valid = 1'b0; in = 32'hdeadbeef;
      repeat (3) @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_bcd", 64'(bcd), 64'd0);
      mon_en = 1'b1;
      rst = 1'b0;

      // Table: one isolated conversion each; the first is on the first edge out of reset.
      for (int i = 0; i < 9; i++) begin
         in = vecs[i].val; in_valid = 1'b1;
         @(negedge clk);
         in_valid = 1'b0; in = $urandom;
         got = 1'b0;
         for (int w = 0; w < LATENCY + 4; w++) begin
            if (out_valid) begin
               got = 1'b1;
               break;
            end
            @(negedge clk);
         end
         check("tbl_seen", 64'(got), 64'd1);
         if (got) check("tbl_bcd", 64'(bcd), 64'(vecs[i].exp));
         @(negedge clk);
         check("tbl_pulse_width", 64'(out_valid), 64'd0);
      end

      // Back-to-back digit-carry boundaries.
      out_log.delete();
      for (int j = 0; j < 4; j++) begin
         in = (j == 0) ? 32'd9 : (j == 1) ? 32'd10 : (j == 2) ? 32'd99 : 32'd100;
         in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      repeat (LATENCY + 3) @(negedge clk);
      check("stream_count", 64'(out_log.size()), 64'd4);
      for (int j = 0; j < 4 && j < out_log.size(); j++) begin
         check("stream_bcd", 64'(out_log[j].bcd), 64'(stream_exp[j]));
         if (j > 0) check("stream_back_to_back", 64'(out_log[j].cyc - out_log[j-1].cyc), 64'd1);
      end

      // Reset mid-stream, before the first of three results emerges.
      rst_edge = (LATENCY < 3) ? 1 : 3;
      exp_post = (rst_edge < 2) ? 2 - rst_edge : 0;
      out_log.delete();
      for (int e = 0; e < 4; e++) begin
         in_valid = (e < 3);
         in = 32'(111 * (e + 1));
         rst = (e == rst_edge);
         @(negedge clk);
         if (e == rst_edge) begin
            check("midrst_out_valid", 64'(out_valid), 64'd0);
            check("midrst_bcd", 64'(bcd), 64'd0);
         end
      end
      rst = 1'b0; in_valid = 1'b0;
      repeat (LATENCY + 3) @(negedge clk);
      check("midrst_post_outputs", 64'(out_log.size()), 64'(exp_post));
      in = 32'd777; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (LATENCY + 2) @(negedge clk);
      check("midrst_new_result", 64'(out_log.size()), 64'(exp_post + 1));
      if (out_log.size() > 0) check("midrst_new_bcd", 64'(out_log[out_log.size()-1].bcd), 64'h777);

      // Random values with random gaps; the scoreboard checks every result.
      for (int i = 0; i < 1000; i++) begin
         in_valid = ($urandom_range(0, 2) != 0);
         in = $urandom;
         @(negedge clk);
      end
      in_valid = 1'b0;
      for (int w = 0; w < LATENCY + 10 && sb_q.size() > 0; w++) @(negedge clk);
      check("drain_empty", 64'(sb_q.size()), 64'd0);
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
